// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, data width and default
// bit period, common to the TX drain and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 868;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Read side of the TX FIFO: empty flag, fall-through head data, pop.
// master = FIFO occupancy controller, slave = uart_tx_fifo_drain.
interface uart_tx_fifo_drain_if;
    import uart_pkg::*;

    logic                      fifo_e;
    logic [UART_DATA_BITS-1:0] fifo_data;
    logic                      fifo_dec;

    modport master (
        output fifo_e,
        output fifo_data,
        input  fifo_dec
    );

    modport slave (
        input  fifo_e,
        input  fifo_data,
        output fifo_dec
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter; tick pulses in the last cycle of each bit.
// Ports: clk, rst (sync, high), load (restart period), tick (boundary).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] TOP = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || cnt == '0) begin
            cnt <= TOP;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART TX draining the TX FIFO: pops one byte per frame and sends
// start, 8 data bits LSB first, optional even parity, stop bit(s).
// Ports: clk, rst (sync, high), fifo (slave), txd (idle high), busy.
// Build option: define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_fifo_drain_if.slave  fifo,
    output logic                 txd,
    output logic                 busy
);

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2);

    logic [2:0]                state;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [2:0]                bit_idx;
    logic                      stop_idx;
    logic                      tick;
    logic                      pop;
`ifdef UART_TX_PARITY_EN
    logic                      par;
`endif

    // Pop only from IDLE with data present; never while held in reset.
    assign pop           = !rst && state == ST_IDLE && !fifo.fifo_e;
    assign fifo.fifo_dec = pop;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (pop),
        .tick (tick)
    );

    // txd is loaded with the level of the state being entered, so the
    // line changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state    <= ST_START;
                        shreg    <= fifo.fifo_data;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par      <= ^fifo.fifo_data;
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        txd   <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            txd   <= par;
`else
                            state <= ST_STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[UART_DATA_BITS-1:1]};
                            txd     <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        txd   <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (stop_idx == LAST_STOP) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
